// File: rtl/regfile_8x8.sv
// 8x8 register file: one synchronous write port, two combinational read ports.
// Optional macro REGFILE_WRITE_BYPASS_EN forwards same-cycle write data to matching read ports.
module regfile_8x8 #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] stored1;
  logic [DATA_W-1:0] stored2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Storage is already cleared while rst is low; gating keeps outputs at zero explicitly.
  assign stored1 = rst ? mem[raddr1] : '0;
  assign stored2 = rst ? mem[raddr2] : '0;

`ifdef REGFILE_WRITE_BYPASS_EN
  assign rdata1 = (rst && we && (raddr1 == waddr)) ? wdata : stored1;
  assign rdata2 = (rst && we && (raddr2 == waddr)) ? wdata : stored2;
`else
  assign rdata1 = stored1;
  assign rdata2 = stored2;
`endif

endmodule

// File: tb/tb_regfile_8x8.sv
// Directed self-checking bench for regfile_8x8.
module tb_regfile_8x8;

  logic       clk;
  logic       rst;
  logic       we;
  logic [2:0] waddr;
  logic [7:0] wdata;
  logic [2:0] raddr1;
  logic [2:0] raddr2;
  logic [7:0] rdata1;
  logic [7:0] rdata2;

  int checks;
  int failures;

  regfile_8x8 dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    we    = 1'b1;
    waddr = a;
    wdata = d;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  // Reads every address on both ports and compares against one value.
  task automatic chk_all(input string tag, input logic [7:0] exp);
    for (int a = 0; a < 8; a++) begin
      raddr1 = 3'(a);
      raddr2 = 3'(7 - a);
      #1;
      chk($sformatf("%s_p1_a%0d", tag, a), rdata1, exp);
      chk($sformatf("%s_p2_a%0d", tag, 7 - a), rdata2, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    we       = 1'b0;
    waddr    = '0;
    wdata    = '0;
    raddr1   = '0;
    raddr2   = '0;

    repeat (2) @(posedge clk);
    #1;
    chk_all("reset_init", 8'h00);

    @(negedge clk);
    rst = 1'b1;
    for (int a = 0; a < 8; a++) wr(3'(a), 8'hFF);
    raddr1 = 3'd3;
    raddr2 = 3'd6;
    #1;
    chk("pre_reset_p1", rdata1, 8'hFF);
    chk("pre_reset_p2", rdata2, 8'hFF);

    // Async clear mid-cycle, checked before any clock edge
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_clear_p1", rdata1, 8'h00);
    chk("async_clear_p2", rdata2, 8'h00);
    we    = 1'b1;
    waddr = 3'd3;
    wdata = 8'h77;
    repeat (2) @(posedge clk);
    #1;
    we = 1'b0;
    chk_all("reset_hold", 8'h00);

    @(negedge clk);
    rst = 1'b1;
    wr(3'd1, 8'hAA);
    wr(3'd2, 8'h55);
    raddr1 = 3'd1;
    raddr2 = 3'd2;
    #1;
    chk("basic_p1_a1", rdata1, 8'hAA);
    chk("basic_p2_a2", rdata2, 8'h55);
    for (int a = 0; a < 8; a++) begin
      if (a != 1 && a != 2) begin
        raddr1 = 3'(a);
        #1;
        chk($sformatf("basic_other_a%0d", a), rdata1, 8'h00);
      end
    end

    @(negedge clk);
    we    = 1'b0;
    waddr = 3'd3;
    wdata = 8'h3C;
    raddr1 = 3'd3;
    repeat (3) @(posedge clk);
    #1;
    chk("we_gate_off", rdata1, 8'h00);
    wr(3'd3, 8'h3C);
    #1;
    chk("we_gate_on", rdata1, 8'h3C);

    for (int a = 0; a < 8; a++) wr(3'(a), 8'h10 + 8'(a));
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        raddr1 = 3'(a);
        raddr2 = 3'(b);
        #1;
        chk($sformatf("sweep_p1_%0d_%0d", a, b), rdata1, 8'h10 + 8'(a));
        chk($sformatf("sweep_p2_%0d_%0d", a, b), rdata2, 8'h10 + 8'(b));
      end
    end

    wr(3'd6, 8'h01);
    wr(3'd6, 8'h02);
    raddr2 = 3'd6;
    #1;
    chk("last_write_wins", rdata2, 8'h02);

    wr(3'd4, 8'h11);
    @(negedge clk);
    we     = 1'b1;
    waddr  = 3'd4;
    wdata  = 8'h22;
    raddr1 = 3'd4;
    raddr2 = 3'd0;
    #1;
`ifdef REGFILE_WRITE_BYPASS_EN
    chk("rdw_before_edge", rdata1, 8'h22);
`else
    chk("rdw_before_edge", rdata1, 8'h11);
`endif
    chk("rdw_other_port", rdata2, 8'h10);
    @(posedge clk);
    #1;
    we = 1'b0;
    chk("rdw_after_edge", rdata1, 8'h22);

    @(negedge clk);
    we     = 1'b1;
    waddr  = 3'd5;
    wdata  = 8'h99;
    raddr1 = 3'd5;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    we  = 1'b0;
    rst = 1'b1;
    #1;
    chk("reset_during_write", rdata1, 8'h00);
    raddr2 = 3'd1;
    #1;
    chk("reset_during_write_other", rdata2, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_8x8.md
Name: regfile_8x8

Overview:
- 8-entry x 8-bit general-purpose register file: one synchronous write port, two independent asynchronous (combinational) read ports.
- Serves as operand storage for a small datapath or CPU core.
- All entries clear on reset.
- Reads are zero-latency so operands are available in the same cycle as the address.

Parameters:
- DATA_W, 8, width of each register and of the wdata/rdata buses.
- DEPTH, 8, number of registers.
- ADDR_W, 3, address width. Must satisfy 2**ADDR_W == DEPTH; no out-of-range addresses are possible.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- we  input  1  write enable, sampled on the rising edge of clk.
- waddr  input  ADDR_W  write address.
- wdata  input  DATA_W  write data.
- raddr1  input  ADDR_W  read port 1 address.
- raddr2  input  ADDR_W  read port 2 address.
- rdata1  output  DATA_W  read port 1 data, combinational from raddr1.
- rdata2  output  DATA_W  read port 2 data, combinational from raddr2.

Behaviour:
- Interface: one clock domain (clk). Reset rst is asynchronous and active-low.

Reset:
- When rst falls to 0, all DEPTH registers clear to 0 immediately, without waiting for a clock edge.
- While rst = 0, writes are ignored and both rdata outputs read 0 for any address.
- Deassertion (rst 0->1) takes effect at the next rising edge. The first write can land on the first rising edge with rst = 1.

Write:
- On posedge clk with rst = 1 and we = 1: mem[waddr] <= wdata.
- With we = 0, no register changes.
- All registers, including address 0, are ordinary writable storage. There is no hardwired zero.
- Write latency: 1 cycle. The new value is visible on a read port immediately after the capturing edge.

Read:
- rdata1 = mem[raddr1] and rdata2 = mem[raddr2], purely combinational.
- No handshake and no read enable.
- Both ports may address the same register and then return identical data.
- Read outputs change within the same cycle when the address changes.

Read-during-write (same address, same cycle, macro absent):
- Before the edge, the read returns the old contents.
- After the edge, it returns the new wdata.

Consecutive writes:
- Back-to-back writes to different addresses on successive cycles all land.
- Back-to-back writes to the same address: the last write wins.

Reset mid-operation:
- Asynchronous reset overrides any write in progress. The register ends at 0 even if we = 1 at the same edge.

X handling:
- No X is ever driven on rdata once reset has been applied once.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined: a read port whose address equals waddr while we = 1 and rst = 1 returns wdata combinationally in the same cycle, i.e. write-through forwarding. This applies to each port independently.
- Not defined: no forwarding. Same-address read-during-write returns the stored (old) value until the capturing edge.
- Storage and write timing are identical in both builds.

Test Plan:
- Reset: hold rst = 0 for 2 cycles after writing 8'hFF to all addresses earlier -> every address reads 8'h00 on both ports. Clearing is immediate on the rst falling edge, without a clock edge.
- Basic write/read: release rst; we = 1, waddr = 1, wdata = 8'hAA; next cycle waddr = 2, wdata = 8'h55; then we = 0; set raddr1 = 1, raddr2 = 2 -> rdata1 = 8'hAA, rdata2 = 8'h55. All other addresses still read 8'h00.
- Write enable gating: we = 0, waddr = 3, wdata = 8'h3C, clock 3 edges -> mem[3] stays 8'h00. Then we = 1 for one edge -> reads 8'h3C.
- Full sweep and dual-port: write addr i with value 8'h10+i for i = 0..7; read all 64 (raddr1, raddr2) pairs -> each port returns 8'h10+addr. Address 0 returns 8'h10.
- Read-during-write: mem[4] = 8'h11; we = 1, waddr = 4, wdata = 8'h22, raddr1 = 4. Before the edge, rdata1 = 8'h11 without the macro and 8'h22 with REGFILE_WRITE_BYPASS_EN. After the edge, rdata1 = 8'h22 in both builds.
- Reset during write: we = 1, waddr = 5, wdata = 8'h99, assert rst = 0 mid-cycle, release after the edge -> mem[5] reads 8'h00.
